// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The sub member exists only when ADDER_SUB_EN is defined.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef ADDER_SUB_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, LSB chunk first; WIDTH must be a multiple of CHUNK.
// Optional subtract mode (sub port) is enabled by defining ADDER_SUB_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_chunk_adder_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_bOperand;
    logic             w_carryIn;
    logic [CHUNK-1:0] w_aChunk;
    logic [CHUNK-1:0] w_bChunk;
    logic [CHUNK:0]   w_chunkSum;
    logic [WIDTH-1:0] w_partialNext;
    logic             w_lastChunk;

    // Subtraction is folded into the operands at acceptance: a + ~b + 1.
`ifdef ADDER_SUB_EN
    assign w_bOperand = bus.sub ? ~bus.b : bus.b;
    assign w_carryIn  = bus.sub | bus.cin;
`else
    assign w_bOperand = bus.b;
    assign w_carryIn  = bus.cin;
`endif

    assign w_aChunk      = CHUNK'(r_a >> (CHUNK * r_count));
    assign w_bChunk      = CHUNK'(r_b >> (CHUNK * r_count));
    assign w_chunkSum    = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_partialNext = r_partial | (WIDTH'(w_chunkSum[CHUNK-1:0]) << (CHUNK * r_count));
    assign w_lastChunk   = (r_count == CW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_stateNext = RUN;
            RUN:     if (w_lastChunk)   w_stateNext = DONE;
            DONE:    if (bus.out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

    // sum/cout only change on completion or reset, so they hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a       <= bus.a;
                        r_b       <= w_bOperand;
                        r_carry   <= w_carryIn;
                        r_partial <= '0;
                        r_count   <= '0;
                    end
                end
                RUN: begin
                    r_carry   <= w_chunkSum[CHUNK];
                    r_partial <= w_partialNext;
                    r_count   <= r_count + 1'b1;
                    if (w_lastChunk) begin
                        r_sum  <= w_partialNext;
                        r_cout <= w_chunkSum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=32, CHUNK=8, plus a CHUNK=32 instance).
// Subtract vectors run only when ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();
    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus32 ();

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Transaction-level model: an accepted operation yields a+b+cin (or a-b) NCH edges later.
    int          cyc = 0;
    bit          mInit = 0;
    bit          mPending = 0;
    int          mAcceptEdge = 0;
    logic [32:0] mExp = '0;
    logic [32:0] mLast = '0;
    bit          mWasValid;
    bit          mWasReady;

    function automatic logic [32:0] expResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    function automatic bit mOutValid();
        return mPending && (cyc >= mAcceptEdge + NCH);
    endfunction

    function automatic logic subIn();
`ifdef ADDER_SUB_EN
        return bus.sub;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        mWasValid = mOutValid();
        mWasReady = !mPending;
        if (rst) begin
            mInit    = 1;
            mPending = 0;
            mLast    = '0;
        end else if (mInit && mWasReady && bus.in_valid) begin
            mPending    = 1;
            mAcceptEdge = cyc + 1;
            mExp        = expResult(bus.a, bus.b, bus.cin, subIn());
        end else if (mInit && mWasValid && bus.out_ready) begin
            mPending = 0;
            mLast    = mExp;
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [32:0] shown;
        if (mInit) begin
            shown = mOutValid() ? mExp : mLast;
            checkOutput("model in_ready", {63'd0, bus.in_ready}, {63'd0, !mPending});
            checkOutput("model out_valid", {63'd0, bus.out_valid}, {63'd0, mOutValid()});
            checkOutput("model sum", {32'd0, bus.sum}, {32'd0, shown[31:0]});
            checkOutput("model cout", {63'd0, bus.cout}, {63'd0, shown[32]});
        end
    end

    task automatic driveOperands(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef ADDER_SUB_EN
        bus.sub = sub;
`endif
    endtask

    // One full operation with literal expectations on latency, result and hold behaviour.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input bit earlyReady,
                                 input int holdCycles, input logic [32:0] expected);
        bit accepted = 0;
        int lat = 0;
        driveOperands(a, b, cin, sub);
        bus.in_valid  = 1'b1;
        bus.out_ready = earlyReady;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(posedge clk); #1;
            accepted = mPending && (mAcceptEdge == cyc);
        end
        checkOutput({name, " accepted"}, {63'd0, accepted}, 64'd1);
        bus.in_valid = 1'b0;
        driveOperands(~a, ~b, ~cin, ~sub);
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, " latency"}, 64'(lat), 64'(NCH));
        checkOutput({name, " result"}, {31'd0, bus.cout, bus.sum}, {31'd0, expected});
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput({name, " hold out_valid"}, {63'd0, bus.out_valid}, 64'd1);
            checkOutput({name, " hold in_ready"}, {63'd0, bus.in_ready}, 64'd0);
            checkOutput({name, " hold result"}, {31'd0, bus.cout, bus.sum}, {31'd0, expected});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput({name, " in_ready after handshake"}, {63'd0, bus.in_ready}, 64'd1);
        checkOutput({name, " out_valid after handshake"}, {63'd0, bus.out_valid}, 64'd0);
        checkOutput({name, " result retained"}, {31'd0, bus.cout, bus.sum}, {31'd0, expected});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
        bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
`ifdef ADDER_SUB_EN
        bus32.sub = 1'b0;
`endif
        driveOperands(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("reset result", {31'd0, bus.cout, bus.sum}, 64'd0);

        applyStimulus("all-ones+cin", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 0, 33'h1_0000_0000);
        applyStimulus("3-chunk carry", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 0, 33'h0_0100_0000);
        applyStimulus("held result", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 3, 33'h0_2345_6789);
        applyStimulus("msb carry", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0, 33'h1_0000_0000);
        applyStimulus("full ripple", 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0, 1'b0, 1, 33'h1_0000_0000);

        // Abort after two RUN edges; in_valid/out_ready raised alongside rst must lose.
        driveOperands(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checkOutput("abort in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("abort out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("abort result", {31'd0, bus.cout, bus.sum}, 64'd0);
        repeat (6) begin
            @(posedge clk); #1;
            checkOutput("abort no out_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        applyStimulus("after abort", 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 0, 33'd7);

`ifdef ADDER_SUB_EN
        applyStimulus("5-7", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 0, 33'h0_FFFF_FFFE);
        applyStimulus("7-5 cin ignored", 32'd7, 32'd5, 1'b1, 1'b1, 1'b0, 0, 33'h1_0000_0002);
`endif

        // Single-chunk instance: result one edge after acceptance.
        bus32.a = 32'd1; bus32.b = 32'd2; bus32.cin = 1'b0;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        checkOutput("chunk32 in_ready after accept", {63'd0, bus32.in_ready}, 64'd0);
        checkOutput("chunk32 out_valid at accept", {63'd0, bus32.out_valid}, 64'd0);
        @(posedge clk); #1;
        checkOutput("chunk32 out_valid", {63'd0, bus32.out_valid}, 64'd1);
        checkOutput("chunk32 result", {31'd0, bus32.cout, bus32.sum}, 64'd3);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        checkOutput("chunk32 in_ready after handshake", {63'd0, bus32.in_ready}, 64'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
